// File: rtl/compressor_if.sv
// Byte-in / item-out handshake bundle for the LZRW1 compressor.
// The source/sink side uses master; the compressor uses slave.
interface compressor_if;
    logic [7:0]  byte_in;
    logic        byte_in_valid;
    logic        byte_in_last;
    logic        compressor_busy;
    logic [15:0] data_out;
    logic        control_word_out;
    logic        out_valid;
    logic        out_ready;
    logic        done;

    modport master (
        output byte_in, byte_in_valid, byte_in_last, out_ready,
        input  compressor_busy, data_out, control_word_out,
        input  out_valid, done
    );

    modport slave (
        input  byte_in, byte_in_valid, byte_in_last, out_ready,
        output compressor_busy, data_out, control_word_out,
        output out_valid, done
    );
endinterface

// File: rtl/compressor_top.sv
// Streaming LZRW1 compressor: single-probe hash over a register ring,
// emitting 16-bit literal/copy items with a control bit.
module compressor_top #(
    parameter int HISTORY_SIZE = 256,
    parameter int HASH_BITS    = 8
) (
    input  logic         clock,
    input  logic         reset,
    compressor_if.slave  io
);
    localparam int RING = 2 * HISTORY_SIZE;
    localparam int RW   = $clog2(RING);
    localparam int TBL  = 1 << HASH_BITS;
    localparam logic [15:0] MAX_OFF = 16'(HISTORY_SIZE - 1);

    typedef enum logic [2:0] {
        FILL, HASH, COMPARE, EMIT, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    wr_pos_q, wr_pos_d;
    logic [15:0]    cur_pos_q, cur_pos_d;
    logic           eos_q, eos_d;
    logic [11:0]    offset_q, offset_d;
    logic [4:0]     len_q, len_d;
    logic [15:0]    data_q, data_d;
    logic           ctrl_q, ctrl_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    logic [7:0]     ring_q [RING];
    logic           tbl_v_q [TBL];
    logic [15:0]    tbl_pos_q [TBL];

    logic [15:0]    avail, avail_d;
    logic           accept;
    logic [RW-1:0]  ci, i1, i2, ca, cb;
    logic [7:0]     b0, b1, b2, h8;
    logic [HASH_BITS-1:0] hidx;
    logic [15:0]    hoff;
    logic           hit;
    logic [4:0]     limit, len_n, len_f;
    logic           eq;
    logic           tbl_we, tbl_clr;

    assign avail  = wr_pos_q - cur_pos_q;
    assign accept = io.byte_in_valid && !busy_q;

    assign ci = RW'(cur_pos_q);
    assign i1 = ci + RW'(1);
    assign i2 = ci + RW'(2);
    assign b0 = ring_q[ci];
    assign b1 = ring_q[i1];
    assign b2 = ring_q[i2];

    assign h8   = b0 ^ {b1[5:0], b1[7:6]} ^ {b2[3:0], b2[7:4]};
    assign hidx = HASH_BITS'(h8);
    assign hoff = cur_pos_q - tbl_pos_q[hidx];
    assign hit  = tbl_v_q[hidx] && (hoff != 16'd0) && (hoff <= MAX_OFF);

    // Compare source may run into the lookahead: overlapping copies.
    assign ca    = ci + RW'(len_q);
    assign cb    = ca - RW'(offset_q);
    assign eq    = ring_q[ca] == ring_q[cb];
    assign limit = (avail >= 16'd18) ? 5'd18 : avail[4:0];
    assign len_n = len_q + 5'd1;
    assign len_f = eq ? len_n : len_q;

    always_comb begin
        state_d   = state_q;
        wr_pos_d  = wr_pos_q;
        cur_pos_d = cur_pos_q;
        eos_d     = eos_q;
        offset_d  = offset_q;
        len_d     = len_q;
        data_d    = data_q;
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        done_d    = done_q;
        tbl_we    = 1'b0;
        tbl_clr   = 1'b0;

        if (accept) begin
            wr_pos_d = wr_pos_q + 16'd1;
            if (io.byte_in_last) eos_d = 1'b1;
        end

        unique case (state_q)
            FILL: begin
                if (avail >= 16'd18 || (eos_q && avail != 16'd0)) begin
                    state_d = HASH;
                end else if (eos_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            HASH: begin
                if (avail >= 16'd3) tbl_we = 1'b1;
                if (avail >= 16'd3 && hit) begin
                    offset_d = hoff[11:0];
                    len_d    = 5'd0;
                    state_d  = COMPARE;
                end else begin
                    data_d  = {8'h00, b0};
                    ctrl_d  = 1'b0;
                    len_d   = 5'd1;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end
            end
            COMPARE: begin
                if (eq && len_n < limit) begin
                    len_d = len_n;
                end else begin
                    valid_d = 1'b1;
                    state_d = EMIT;
                    if (len_f >= 5'd3) begin
                        data_d = {4'(len_f - 5'd3), offset_q};
                        ctrl_d = 1'b1;
                        len_d  = len_f;
                    end else begin
                        data_d = {8'h00, b0};
                        ctrl_d = 1'b0;
                        len_d  = 5'd1;
                    end
                end
            end
            EMIT: begin
                if (io.out_ready) begin
                    valid_d   = 1'b0;
                    cur_pos_d = cur_pos_q + {11'd0, len_q};
                    state_d   = FILL;
                end
            end
            DONE: begin
                done_d    = 1'b0;
                wr_pos_d  = 16'd0;
                cur_pos_d = 16'd0;
                eos_d     = 1'b0;
                tbl_clr   = 1'b1;
                state_d   = FILL;
            end
            default: state_d = FILL;
        endcase

        avail_d = wr_pos_d - cur_pos_d;
        busy_d  = (avail_d >= 16'd18) || eos_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FILL;
            wr_pos_q  <= 16'd0;
            cur_pos_q <= 16'd0;
            eos_q     <= 1'b0;
            offset_q  <= 12'd0;
            len_q     <= 5'd0;
            data_q    <= 16'd0;
            ctrl_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            for (int i = 0; i < TBL; i++) begin
                tbl_v_q[i]   <= 1'b0;
                tbl_pos_q[i] <= 16'd0;
            end
        end else begin
            state_q   <= state_d;
            wr_pos_q  <= wr_pos_d;
            cur_pos_q <= cur_pos_d;
            eos_q     <= eos_d;
            offset_q  <= offset_d;
            len_q     <= len_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            if (tbl_clr) begin
                for (int i = 0; i < TBL; i++) tbl_v_q[i] <= 1'b0;
            end else if (tbl_we) begin
                tbl_v_q[hidx]   <= 1'b1;
                tbl_pos_q[hidx] <= cur_pos_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) ring_q[RW'(wr_pos_q)] <= io.byte_in;
    end

    assign io.data_out         = data_q;
    assign io.control_word_out = ctrl_q;
    assign io.out_valid        = valid_q;
    assign io.done             = done_q;
    assign io.compressor_busy  = busy_q;
endmodule

// File: tb/tb_compressor_top.sv
// Scoreboard bench for compressor_top: directed streams, expected items
// queued at stimulus time and checked by an independent output monitor.
module tb_compressor_top;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   consumed = 0;
    bit   stall_mode = 1'b0;
    logic [16:0] exp_q [$];

    compressor_if io ();

    compressor_top #(.HISTORY_SIZE(256), .HASH_BITS(8)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [16:0] got,
                         input logic [16:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic expect_item(input logic ctrl, input logic [15:0] d);
        exp_q.push_back({ctrl, d});
    endtask

    // Output monitor: pops one expected item per transfer.
    logic        hold_prev = 1'b0;
    logic [16:0] prev_item = '0;
    always @(negedge clock) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (!io.out_valid ||
                    {io.control_word_out, io.data_out} !== prev_item) begin
                    failures++;
                    $display("FAIL hold_stable got=%b/%h want=1/%h",
                             io.out_valid,
                             {io.control_word_out, io.data_out}, prev_item);
                end
            end
            if (io.out_valid && io.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_item got=%h want=none",
                             {io.control_word_out, io.data_out});
                end else begin
                    check("item", {io.control_word_out, io.data_out},
                          exp_q.pop_front());
                end
            end
            hold_prev = io.out_valid && !io.out_ready;
            prev_item = {io.control_word_out, io.data_out};
            if (io.done) done_cnt++;
        end
    end

    always @(posedge clock) begin
        if (!reset && io.byte_in_valid && !io.compressor_busy) consumed++;
    end

    // Sink: always ready, or in stall mode hold off 10 cycles per item.
    int stall_cnt = 0;
    always begin
        @(posedge clock);
        #1;
        if (!stall_mode) begin
            io.out_ready = 1'b1;
            stall_cnt = 0;
        end else if (io.out_valid) begin
            if (stall_cnt < 10) begin
                io.out_ready = 1'b0;
                stall_cnt++;
            end else begin
                io.out_ready = 1'b1;
                stall_cnt = 0;
            end
        end else begin
            io.out_ready = 1'b0;
            stall_cnt = 0;
        end
    end

    task automatic send(input logic [7:0] b, input logic last);
        int t = 0;
        io.byte_in       = b;
        io.byte_in_valid = 1'b1;
        io.byte_in_last  = last;
        while (io.compressor_busy && t < 2000) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (t >= 2000) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=busy want=accept");
        end
        @(posedge clock);
        #1;
        io.byte_in_valid = 1'b0;
        io.byte_in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last);
        for (int i = 0; i < s.len(); i++)
            send(s[i], last && (i == s.len() - 1));
    endtask

    task automatic wait_done(input int start, input string name);
        int t = 0;
        while (done_cnt == start && t < 3000) begin
            @(posedge clock);
            #1;
            t++;
        end
        check({name, "_done"}, 17'(done_cnt), 17'(start + 1));
        repeat (5) @(posedge clock);
        #1;
        check({name, "_done_once"}, 17'(done_cnt), 17'(start + 1));
        check({name, "_items_left"}, 17'(exp_q.size()), 17'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_data"}, {1'b0, io.data_out}, 17'd0);
        check({name, "_ctrl"}, 17'(io.control_word_out), 17'd0);
        check({name, "_valid"}, 17'(io.out_valid), 17'd0);
        check({name, "_done"}, 17'(io.done), 17'd0);
        check({name, "_busy"}, 17'(io.compressor_busy), 17'd1);
    endtask

    initial begin
        int start;
        int c0;
        io.byte_in       = 8'h00;
        io.byte_in_valid = 1'b0;
        io.byte_in_last  = 1'b0;
        io.out_ready     = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("rst_busy_release", 17'(io.compressor_busy), 17'd0);

        start = done_cnt;
        expect_item(1'b0, 16'h0061);
        expect_item(1'b0, 16'h0062);
        expect_item(1'b0, 16'h0063);
        send_str("abc", 1'b1);
        wait_done(start, "abc");

        start = done_cnt;
        expect_item(1'b0, 16'h0061);
        expect_item(1'b0, 16'h0062);
        expect_item(1'b0, 16'h0063);
        expect_item(1'b1, 16'h3003);
        send_str("abcabcabc", 1'b1);
        wait_done(start, "abc3");

        start = done_cnt;
        expect_item(1'b0, 16'h0041);
        expect_item(1'b1, 16'hF001);
        expect_item(1'b0, 16'h0041);
        send_str("AAAAAAAAAAAAAAAAAAAA", 1'b1);
        wait_done(start, "a20");

        stall_mode = 1'b1;
        start = done_cnt;
        expect_item(1'b0, 16'h0061);
        expect_item(1'b0, 16'h0062);
        expect_item(1'b0, 16'h0063);
        expect_item(1'b1, 16'h3003);
        send_str("abcabcabc", 1'b1);
        wait_done(start, "stall");
        stall_mode = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        start = done_cnt;
        c0 = consumed;
        expect_item(1'b0, 16'h0041);
        expect_item(1'b1, 16'hF001);
        expect_item(1'b1, 16'h8012);
        for (int i = 0; i < 30; i++) send(8'h41, i == 29);
        wait_done(start, "a30");
        check("a30_consumed", 17'(consumed - c0), 17'd30);

        send_str("abcab", 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_outputs("midrst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        start = done_cnt;
        expect_item(1'b0, 16'h0061);
        expect_item(1'b0, 16'h0062);
        expect_item(1'b0, 16'h0063);
        send_str("abc", 1'b1);
        wait_done(start, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
